// File: rtl/router_pkg.sv
// Shared definitions for the router operand/result issuer: opcodes, widths,
// issuer state encoding, the queued request record and small helpers.
package router_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_AND = 4'd3;
    localparam logic [OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [OP_W-1:0] OP_NOT = 4'd6;
    localparam logic [OP_W-1:0] OP_SHL = 4'd7;
    localparam logic [OP_W-1:0] OP_SHR = 4'd8;
    localparam logic [OP_W-1:0] OP_MAX = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } issuer_state_t;

    // 40-bit queue entry, packed as {tag, op, b, a}
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } req_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_MAX;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/router_op_issuer_if.sv
// Host request/response and router operand/result signals of the issuer.
// slave = issuer view, master = host/router environment view.
interface router_op_issuer_if;
    import router_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [TAG_W-1:0]  req_tag;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [OP_W-1:0]   req_op;

    logic              rtr_enable;
    logic [DATA_W-1:0] rtr_a;
    logic [DATA_W-1:0] rtr_b;
    logic [OP_W-1:0]   rtr_op;
    logic [DATA_W-1:0] rtr_result;
    logic              rtr_valid;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_tag, req_a, req_b, req_op,
        input  rtr_result, rtr_valid, rsp_ready,
        output req_ready, rtr_enable, rtr_a, rtr_b, rtr_op,
        output rsp_valid, rsp_tag, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_tag, req_a, req_b, req_op,
        output rtr_result, rtr_valid, rsp_ready,
        input  req_ready, rtr_enable, rtr_a, rtr_b, rtr_op,
        input  rsp_valid, rsp_tag, rsp_data, rsp_err
    );

endinterface

// File: rtl/router_req_fifo.sv
// Request queue for the issuer; the head is visible before pop so the issuer
// can classify the opcode in the same cycle it dequeues.
module router_req_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  req_t                   wr_data,
    output req_t                   rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    req_t              mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/router_op_issuer.sv
// Initiator side of the router operand/result interface: queues host requests,
// issues one at a time, returns result/tag/status. Optional counters: ROUTER_OP_ISSUER_STATS_EN.
module router_op_issuer
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    router_op_issuer_if.slave   bus,
    output logic                busy
`ifdef ROUTER_OP_ISSUER_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [15:0]         stat_done,
    output logic [15:0]         stat_timeout
`endif
);
    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    issuer_state_t               state_reg, state_next;
    req_t                        iss_reg, iss_next;
    logic [7:0]                  settle_reg, settle_next;
    logic [7:0]                  tmo_reg, tmo_next;
    logic [DATA_W-1:0]           data_reg, data_next;
    logic                        err_reg, err_next;
    logic                        pop;
    req_t                        head;
    req_t                        wr_req;
    logic                        full, empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign wr_req = '{tag: bus.req_tag, op: bus.req_op, b: bus.req_b, a: bus.req_a};

    router_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.req_valid),
        .pop     (pop),
        .wr_data (wr_req),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            iss_reg    <= '0;
            settle_reg <= '0;
            tmo_reg    <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            iss_reg    <= iss_next;
            settle_reg <= settle_next;
            tmo_reg    <= tmo_next;
            data_reg   <= data_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        iss_next    = iss_reg;
        settle_next = settle_reg;
        tmo_next    = tmo_reg;
        data_next   = data_reg;
        err_next    = err_reg;
        pop         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    iss_next    = head;
                    settle_next = '0;
                    tmo_next    = '0;
                    // Illegal opcodes are answered directly without touching the router
                    if (op_legal(head.op)) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = RESP;
                        err_next   = 1'b1;
                        data_next  = '0;
                    end
                end
            end
            ISSUE: begin
                settle_next = sat_inc8(settle_reg);
                if (settle_reg == SETTLE_LAST) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.rtr_valid) begin
                    data_next  = bus.rtr_result;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (tmo_reg == TIMEOUT_LAST) begin
                    data_next  = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    tmo_next = sat_inc8(tmo_reg);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready  = !full;
    assign bus.rtr_enable = (state_reg == ISSUE) || (state_reg == WAIT);
    assign bus.rtr_a      = iss_reg.a;
    assign bus.rtr_b      = iss_reg.b;
    assign bus.rtr_op     = iss_reg.op;
    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_tag    = iss_reg.tag;
    assign bus.rsp_data   = data_reg;
    assign bus.rsp_err    = err_reg;
    assign busy           = (state_reg != IDLE) || (fifo_count != '0);

`ifdef ROUTER_OP_ISSUER_STATS_EN
    logic [15:0] done_cnt_reg;
    logic [15:0] tmo_cnt_reg;
    logic        rsp_hs;

    assign rsp_hs = (state_reg == RESP) && bus.rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
        end else if (stat_clr) begin
            done_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
        end else if (rsp_hs) begin
            if (err_reg) begin
                if (tmo_cnt_reg != 16'hFFFF) tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
            end else begin
                if (done_cnt_reg != 16'hFFFF) done_cnt_reg <= done_cnt_reg + 16'd1;
            end
        end
    end

    assign stat_done    = done_cnt_reg;
    assign stat_timeout = tmo_cnt_reg;
`endif

endmodule

// File: tb/tb_router_op_issuer.sv
// Directed + randomized bench for router_op_issuer with a behavioural router
// and an in-order expected-response queue.
module tb_router_op_issuer;
    import router_pkg::*;

    localparam int SETTLE = 2;
    localparam int TMO    = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy;
`ifdef ROUTER_OP_ISSUER_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_done;
    logic [15:0] stat_timeout;
`endif

    router_op_issuer_if ifc ();

    router_op_issuer #(
        .FIFO_DEPTH     (4),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc),
        .busy  (busy)
`ifdef ROUTER_OP_ISSUER_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_done    (stat_done),
        .stat_timeout (stat_timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return 16'(a * b);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOT:  return ~a;
            OP_SHL:  return a << b[3:0];
            OP_SHR:  return a >> b[3:0];
            default: return 16'h0;
        endcase
    endfunction

    // Behavioural router: answers lat cycles after enable rises; in stale mode
    // it keeps its last valid/result asserted until the new answer is ready.
    int   lat_cfg    = 3;
    bit   rand_lat   = 1'b0;
    bit   stale_mode = 1'b0;
    int   en_cycles  = 0;
    int   en_pulses  = 0;
    int   last_len   = 0;
    int   cur_lat    = 3;

    always @(negedge clk) begin
        if (ifc.rtr_enable) begin
            if (en_cycles == 0) begin
                en_pulses++;
                cur_lat = rand_lat ? int'($urandom_range(1, 6)) : lat_cfg;
            end
            en_cycles++;
            last_len = en_cycles;
            if (en_cycles >= cur_lat) begin
                ifc.rtr_valid  = 1'b1;
                ifc.rtr_result = alu(ifc.rtr_op, ifc.rtr_a, ifc.rtr_b);
            end else if (!stale_mode) begin
                ifc.rtr_valid  = 1'b0;
                ifc.rtr_result = 16'h0;
            end
        end else begin
            en_cycles = 0;
            if (!stale_mode) begin
                ifc.rtr_valid  = 1'b0;
                ifc.rtr_result = 16'h0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input bit tmo);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        ifc.req_tag   = tag;
        ifc.req_a     = a;
        ifc.req_b     = b;
        ifc.req_op    = op;
        ifc.req_valid = 1'b1;
        while (!ifc.req_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("push_ready", ifc.req_ready, 1'b1);
        e.tag  = tag;
        e.err  = (op > OP_MAX) || tmo;
        e.data = e.err ? 16'h0 : alu(op, a, b);
        exp_q.push_back(e);
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string name, input int hold);
        int   w = 0;
        exp_t e;
        while (!ifc.rsp_valid && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk({name, ".valid"}, ifc.rsp_valid, 1'b1);
        chk({name, ".enable_low"}, ifc.rtr_enable, 1'b0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue: observed response tag %0h expected none", name, ifc.rsp_tag);
        end else begin
            e = exp_q.pop_front();
            chk({name, ".tag"}, ifc.rsp_tag, e.tag);
            chk({name, ".data"}, ifc.rsp_data, e.data);
            chk({name, ".err"}, ifc.rsp_err, e.err);
            repeat (hold) @(negedge clk);
            if (hold > 0) begin
                chk({name, ".hold_valid"}, ifc.rsp_valid, 1'b1);
                chk({name, ".hold_tag"}, ifc.rsp_tag, e.tag);
                chk({name, ".hold_data"}, ifc.rsp_data, e.data);
            end
        end
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1 ifc.rsp_ready = 1'b0;
        chk({name, ".valid_fall"}, ifc.rsp_valid, 1'b0);
    endtask

    initial begin
        int p0;
        int w;
        ifc.req_valid = 1'b0;
        ifc.req_tag   = '0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.req_op    = '0;
        ifc.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.req_ready", ifc.req_ready, 1'b1);
        chk("rst.enable", ifc.rtr_enable, 1'b0);
        chk("rst.rsp_valid", ifc.rsp_valid, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.rsp_tag", ifc.rsp_tag, 4'h0);
        chk("rst.rsp_data", ifc.rsp_data, 16'h0);
        chk("rst.rtr_a", ifc.rtr_a, 16'h0);
        reset = 1'b1;

        // Single request, router answers 3 cycles after enable
        lat_cfg = 3;
        p0 = en_pulses;
        push(4'h5, 16'h0010, 16'h0020, OP_ADD, 1'b0);
        expect_rsp("single", 2);
        chk("single.pulses", en_pulses - p0, 1);
        chk("single.len", last_len, 3);

        // Stale valid held through the settle window of the next op
        stale_mode = 1'b1;
        push(4'hE, 16'h0100, 16'h0001, OP_ADD, 1'b0);
        expect_rsp("stale_prep", 0);
        push(4'h1, 16'h0005, 16'h0003, OP_SUB, 1'b0);
        expect_rsp("stale", 1);
        stale_mode = 1'b0;

        // Fill: one in flight plus four queued
        for (int i = 0; i < 5; i++) begin
            push(4'(i), 16'(16'h0100 + i), 16'(i + 1), OP_XOR, 1'b0);
        end
        chk("full.req_ready", ifc.req_ready, 1'b0);
        chk("full.busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            expect_rsp($sformatf("drain%0d", i), 0);
        end

        // Timeout
        lat_cfg = 10000;
        push(4'hA, 16'h1234, 16'h0001, OP_ADD, 1'b1);
        expect_rsp("timeout", 1);
        chk("timeout.len", last_len, SETTLE + TMO);

        // Illegal opcode never reaches the router
        lat_cfg = 3;
        p0 = en_pulses;
        push(4'h7, 16'h0001, 16'h0002, 4'hC, 1'b0);
        expect_rsp("illegal", 1);
        chk("illegal.pulses", en_pulses - p0, 0);

        // Randomized traffic with random router latency and response back-pressure
        rand_lat = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [3:0] op;
                    op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                    push(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), op, 1'b0);
                end
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    expect_rsp($sformatf("rand%0d", i), int'($urandom_range(0, 2)));
                end
            end
        join
        rand_lat = 1'b0;
        chk("rand.idle", busy, 1'b0);

        // Reset while waiting on the router, with further requests queued
        lat_cfg = 10000;
        push(4'h9, 16'h0001, 16'h0001, OP_ADD, 1'b0);
        push(4'hB, 16'h0002, 16'h0002, OP_ADD, 1'b0);
        push(4'hC, 16'h0003, 16'h0003, OP_ADD, 1'b0);
        w = 0;
        while (!ifc.rtr_enable && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        chk("pre_reset.enable", ifc.rtr_enable, 1'b1);
        reset = 1'b0;
        #1;
        chk("async.enable", ifc.rtr_enable, 1'b0);
        chk("async.rsp_valid", ifc.rsp_valid, 1'b0);
        chk("async.busy", busy, 1'b0);
        chk("async.req_ready", ifc.req_ready, 1'b1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset.rsp_valid", ifc.rsp_valid, 1'b0);
        chk("post_reset.enable", ifc.rtr_enable, 1'b0);
        lat_cfg = 3;
        push(4'h3, 16'h00F0, 16'h0004, OP_SHR, 1'b0);
        expect_rsp("post_reset", 1);
`ifdef ROUTER_OP_ISSUER_STATS_EN
        chk("stats.done", stat_done, 16'd1);
        chk("stats.timeout", stat_timeout, 16'd0);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stats.clr", stat_done, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
